// File: rtl/mult_8x8_seq_ctrl_pkg.sv
// Shared definitions for the sequential 8x8 multiplier: FSM encoding,
// combine-mode constants and the per-step partial-product shift table.
package mult_8x8_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic MODE_EXACT = 1'b0;
   localparam logic MODE_OR    = 1'b1;

   localparam logic [1:0] STEP_LAST = 2'd3;

   // Shift applied to the partial product of each step: lo*lo, lo*hi, hi*lo, hi*hi.
   function automatic logic [3:0] step_shift(input logic [1:0] step);
      case (step)
         2'd0:    step_shift = 4'd0;
         2'd1:    step_shift = 4'd4;
         2'd2:    step_shift = 4'd4;
         default: step_shift = 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/mult_8x8_seq_ctrl_core.sv
// Shared 4x4 unsigned multiplier; nibble selection lives in the controller.
module mult_4x4_core (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic [7:0] p_o
);

   // Exact product of two nibbles, 8 bits wide so it can never overflow.
   assign p_o = {4'h0, a_i} * {4'h0, b_i};

endmodule

// File: rtl/mult_8x8_seq_ctrl.sv
// Sequential 8x8 multiplier: one 4x4 partial product per cycle, combined by
// add (exact) or bitwise OR (approximate) into a 16-bit accumulator.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for operands; accumulator holds the last result
// MUL     | step_q selects the partial product folded in on the next edge
// DONE    | result on R with out_valid held until out_ready
module mult_8x8_seq_ctrl
   import mult_8x8_seq_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   input  logic        mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] R,
   output logic        busy
);

   state_e      state_q;
   logic [1:0]  step_q;
   logic [15:0] acc_q;
   logic [15:0] acc_d;
   logic [7:0]  a_q;
   logic [7:0]  b_q;
   logic        mode_q;
   logic        in_ready_q;
   logic        out_valid_q;
   logic        busy_q;

   logic [3:0]  nib_a;
   logic [3:0]  nib_b;
   logic [7:0]  pp;
   logic [15:0] pp_shifted;

   mult_4x4_core u_core (
      .a_i (nib_a),
      .b_i (nib_b),
      .p_o (pp)
   );

   // Step bit 1 picks the A nibble, bit 0 the B nibble; combine per latched mode.
   always_comb begin
      nib_a      = step_q[1] ? a_q[7:4] : a_q[3:0];
      nib_b      = step_q[0] ? b_q[7:4] : b_q[3:0];
      pp_shifted = {8'h00, pp} << step_shift(step_q);
      acc_d      = (mode_q == MODE_OR) ? (acc_q | pp_shifted) : (acc_q + pp_shifted);
   end

   // Controller FSM with registered handshake and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         step_q      <= 2'd0;
         acc_q       <= 16'h0000;
         a_q         <= 8'h00;
         b_q         <= 8'h00;
         mode_q      <= MODE_EXACT;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q        <= A;
                  b_q        <= B;
                  mode_q     <= mode;
                  acc_q      <= 16'h0000;
                  step_q     <= 2'd0;
                  state_q    <= ST_MUL;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ST_MUL: begin
               acc_q  <= acc_d;
               step_q <= step_q + 2'd1;
               if (step_q == STEP_LAST) begin
                  state_q     <= ST_DONE;
                  out_valid_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               step_q      <= 2'd0;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign R         = acc_q;

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Self-checking bench for mult_8x8_seq_ctrl: directed corner sequences,
// a vector table and a randomized regression, results checked via a queue.
module tb_mult_8x8_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  A = 8'h00;
   logic [7:0]  B = 8'h00;
   logic        mode = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] R;
   logic        busy;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        m;
      logic [15:0] r;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   mult_8x8_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .R         (R),
      .busy      (busy)
   );

   // Exact mode is the true product; OR mode merges the four shifted nibble products.
   function automatic logic [15:0] ref_model(input logic [7:0] a, input logic [7:0] b, input logic m);
      logic [15:0] acc;
      logic [15:0] p;
      if (!m) return {8'h00, a} * {8'h00, b};
      acc = 16'h0000;
      p = {12'h000, a[3:0]} * {12'h000, b[3:0]};  acc = acc | p;
      p = {12'h000, a[3:0]} * {12'h000, b[7:4]};  acc = acc | (p << 4);
      p = {12'h000, a[7:4]} * {12'h000, b[3:0]};  acc = acc | (p << 4);
      p = {12'h000, a[7:4]} * {12'h000, b[7:4]};  acc = acc | (p << 8);
      return acc;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present operands until accepted, recording the expected result.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic m, input logic [15:0] r);
      bit ok;
      ok = 1'b0;
      A = a; B = b; mode = m; in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) exp_q.push_back(r);
      else check("accept_timeout", 32'd0, 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   // Wait for out_valid, stall the consumer for hold cycles, then take the result.
   task automatic drain(input int hold);
      bit seen;
      seen = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("done_timeout", 32'd0, 32'd1);
      step();
      repeat (hold) step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic        rm;
      logic [15:0] held_r;
      bit          saw_valid;

      vecs[0] = '{a: 8'h12, b: 8'h34, m: 1'b1, r: 16'h0368};
      vecs[1] = '{a: 8'hFF, b: 8'hFF, m: 1'b1, r: 16'hEFF1};
      vecs[2] = '{a: 8'hFF, b: 8'hFF, m: 1'b0, r: 16'hFE01};
      vecs[3] = '{a: 8'h12, b: 8'h34, m: 1'b0, r: 16'h03A8};
      vecs[4] = '{a: 8'h00, b: 8'hAB, m: 1'b0, r: 16'h0000};
      vecs[5] = '{a: 8'h80, b: 8'h02, m: 1'b0, r: 16'h0100};
      vecs[6] = '{a: 8'h0F, b: 8'hF0, m: 1'b1, r: 16'h0E10};

      // Scoreboard monitor: every consumed result must match the oldest expectation.
      fork
         forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb_spurious: got R=%0h with no pending operation at %0t", R, $time);
               end else begin
                  check("sb_R", {16'h0, R}, {16'h0, exp_q.pop_front()});
               end
            end
         end
      join_none

      // Reset values.
      #2 rst_n = 1'b0;
      repeat (2) step();
      check("rst_in_ready", {31'h0, in_ready}, 32'd1);
      check("rst_out_valid", {31'h0, out_valid}, 32'd0);
      check("rst_busy", {31'h0, busy}, 32'd0);
      check("rst_R", {16'h0, R}, 32'd0);
      rst_n = 1'b1;
      step();

      // Latency, ignored mid-operation request, backpressure and release.
      issue(8'h12, 8'h34, 1'b0, 16'h03A8);
      in_valid = 1'b1; A = 8'h01; B = 8'h01;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("lat_out_valid_low", {31'h0, out_valid}, 32'd0);
         check("mul_busy", {31'h0, busy}, 32'd1);
         check("mul_in_ready", {31'h0, in_ready}, 32'd0);
      end
      @(negedge clk);
      check("lat_out_valid_high", {31'h0, out_valid}, 32'd1);
      check("exact_12x34", {16'h0, R}, 32'h03A8);
      held_r = R;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_out_valid", {31'h0, out_valid}, 32'd1);
         check("bp_R", {16'h0, R}, {16'h0, held_r});
         step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      @(negedge clk);
      check("rel_in_ready", {31'h0, in_ready}, 32'd1);
      check("rel_out_valid", {31'h0, out_valid}, 32'd0);
      saw_valid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      check("no_second_valid", {31'h0, saw_valid}, 32'd0);
      step();

      // Vector table.
      for (int i = 0; i < 7; i++) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].r);
         drain(i % 3);
      end

      // Reset during MUL step 2 discards the operation.
      issue(8'hAB, 8'hCD, 1'b0, ref_model(8'hAB, 8'hCD, 1'b0));
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", {31'h0, in_ready}, 32'd1);
      check("midrst_out_valid", {31'h0, out_valid}, 32'd0);
      check("midrst_busy", {31'h0, busy}, 32'd0);
      check("midrst_R", {16'h0, R}, 32'd0);
      exp_q.delete();
      step();
      rst_n = 1'b1;
      saw_valid = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      check("midrst_no_valid", {31'h0, saw_valid}, 32'd0);
      step();
      issue(8'h03, 8'h05, 1'b0, 16'h000F);
      drain(1);

      // Randomized regression with request and consumer gaps.
      for (int n = 0; n < 1000; n++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rm = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 2)) step();
         issue(ra, rb, rm, ref_model(ra, rb, rm));
         drain(int'($urandom_range(0, 3)));
      end

      repeat (3) step();
      check("sb_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
